// File: rtl/dtcm_arb_pkg.sv
// Shared types and constants for the data-TCM arbiter between the core LSU and the host port.
package dtcm_arb_pkg;

  typedef enum logic {
    OWNER_CORE = 1'b0,
    OWNER_HOST = 1'b1
  } owner_e;

  localparam int unsigned STARVE_MAX_DEFAULT = 4;
  localparam int unsigned WORD_W             = 32;

endpackage

// File: rtl/dtcm_arb_rsp_stage.sv
// Response stage: remembers who owns the access in flight and steers the 1-cycle SRAM
// read data (or a zero write ack) to that requester only.
module dtcm_arb_rsp_stage
  import dtcm_arb_pkg::*;
(
  input  logic              clk,
  input  logic              cpurst,
  input  logic              accept,
  input  owner_e            owner,
  input  logic              is_rd,
  input  logic [WORD_W-1:0] ram_rdata,
  output logic              core_rsp_valid,
  output logic [WORD_W-1:0] core_rsp_rdata,
  output logic              host_rsp_valid,
  output logic [WORD_W-1:0] host_rsp_rdata
);

  logic              rsp_pend;
  owner_e            rsp_owner;
  logic              rsp_is_rd;
  logic              live;
  logic [WORD_W-1:0] data;

  always_ff @(posedge clk) begin
    if (cpurst) begin
      rsp_pend  <= 1'b0;
      rsp_owner <= OWNER_CORE;
      rsp_is_rd <= 1'b0;
    end else begin
      rsp_pend  <= accept;
      rsp_owner <= owner;
      rsp_is_rd <= is_rd;
    end
  end

  // Reset in the response cycle drops the pending entry combinationally.
  always_comb begin
    live           = rsp_pend && !cpurst;
    data           = rsp_is_rd ? ram_rdata : '0;
    core_rsp_valid = live && (rsp_owner == OWNER_CORE);
    host_rsp_valid = live && (rsp_owner == OWNER_HOST);
    core_rsp_rdata = core_rsp_valid ? data : '0;
    host_rsp_rdata = host_rsp_valid ? data : '0;
  end

endmodule

// File: rtl/dtcm_arbiter.sv
// Single-port DTCM arbiter: core wins by default, host wins when the core is idle or
// after STARVE_MAX consecutive denied cycles.
module dtcm_arbiter
  import dtcm_arb_pkg::*;
#(
  parameter int unsigned AW         = 14,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic              clk,
  input  logic              cpurst,
  input  logic              core_req_valid,
  output logic              core_req_ready,
  input  logic [AW-1:0]     core_req_addr,
  input  logic              core_req_we,
  input  logic [3:0]        core_req_wstrb,
  input  logic [WORD_W-1:0] core_req_wdata,
  output logic              core_rsp_valid,
  output logic [WORD_W-1:0] core_rsp_rdata,
  input  logic              host_req_valid,
  output logic              host_req_ready,
  input  logic [AW-1:0]     host_req_addr,
  input  logic              host_req_we,
  input  logic [3:0]        host_req_wstrb,
  input  logic [WORD_W-1:0] host_req_wdata,
  output logic              host_rsp_valid,
  output logic [WORD_W-1:0] host_rsp_rdata,
  output logic              ram_cs,
  output logic [3:0]        ram_we,
  output logic [AW-3:0]     ram_addr,
  output logic [WORD_W-1:0] ram_wdata,
  input  logic [WORD_W-1:0] ram_rdata
);

  logic [3:0] starve_cnt;
  logic       starve_hit;
  logic       host_win;
  logic       core_grant;
  logic       host_grant;
  logic       accept;
  logic       sel_we;
  logic [3:0] sel_wstrb;
  owner_e     owner;
  logic       unused_addr_lsbs;

  assign unused_addr_lsbs = ^{core_req_addr[1:0], host_req_addr[1:0]};

  always_comb begin
    starve_hit     = (starve_cnt == 4'(STARVE_MAX));
    host_win       = host_req_valid && (!core_req_valid || starve_hit);
    host_grant     = !cpurst && host_win;
    core_grant     = !cpurst && core_req_valid && !host_win;
    core_req_ready = core_grant;
    host_req_ready = host_grant;
    accept         = core_grant || host_grant;
    owner          = host_grant ? OWNER_HOST : OWNER_CORE;
    sel_we         = host_grant ? host_req_we    : core_req_we;
    sel_wstrb      = host_grant ? host_req_wstrb : core_req_wstrb;
    ram_cs         = accept;
    ram_we         = (accept && sel_we) ? sel_wstrb : '0;
    ram_addr       = host_grant ? host_req_addr[AW-1:2] : core_req_addr[AW-1:2];
    ram_wdata      = host_grant ? host_req_wdata : core_req_wdata;
  end

  always_ff @(posedge clk) begin
    if (cpurst || !host_req_valid || host_grant) begin
      starve_cnt <= '0;
    end else if (!starve_hit) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  dtcm_arb_rsp_stage u_rsp (
    .clk            (clk),
    .cpurst         (cpurst),
    .accept         (accept),
    .owner          (owner),
    .is_rd          (!sel_we),
    .ram_rdata      (ram_rdata),
    .core_rsp_valid (core_rsp_valid),
    .core_rsp_rdata (core_rsp_rdata),
    .host_rsp_valid (host_rsp_valid),
    .host_rsp_rdata (host_rsp_rdata)
  );

endmodule

// File: tb/tb_dtcm_arbiter.sv
// Directed bench for dtcm_arbiter with a byte-lane SRAM fixture and a response scoreboard.
module tb_dtcm_arbiter;
  import dtcm_arb_pkg::*;

  localparam int unsigned AW   = 14;
  localparam int unsigned SMAX = 4;

  logic        clk = 1'b0;
  logic        cpurst;
  logic        core_req_valid, core_req_ready, core_req_we, core_rsp_valid;
  logic [AW-1:0] core_req_addr;
  logic [3:0]  core_req_wstrb;
  logic [31:0] core_req_wdata, core_rsp_rdata;
  logic        host_req_valid, host_req_ready, host_req_we, host_rsp_valid;
  logic [AW-1:0] host_req_addr;
  logic [3:0]  host_req_wstrb;
  logic [31:0] host_req_wdata, host_rsp_rdata;
  logic        ram_cs;
  logic [3:0]  ram_we;
  logic [AW-3:0] ram_addr;
  logic [31:0] ram_wdata, ram_rdata;

  always #5 clk = ~clk;

  dtcm_arbiter #(.AW(AW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .cpurst(cpurst),
    .core_req_valid(core_req_valid), .core_req_ready(core_req_ready),
    .core_req_addr(core_req_addr), .core_req_we(core_req_we),
    .core_req_wstrb(core_req_wstrb), .core_req_wdata(core_req_wdata),
    .core_rsp_valid(core_rsp_valid), .core_rsp_rdata(core_rsp_rdata),
    .host_req_valid(host_req_valid), .host_req_ready(host_req_ready),
    .host_req_addr(host_req_addr), .host_req_we(host_req_we),
    .host_req_wstrb(host_req_wstrb), .host_req_wdata(host_req_wdata),
    .host_rsp_valid(host_rsp_valid), .host_rsp_rdata(host_rsp_rdata),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // SRAM fixture: byte-lane writes, registered read data, preload port used under reset.
  logic [31:0] mem [4096];
  logic [31:0] rdq = '0;
  logic        pre_en = 1'b0;
  logic [11:0] pre_addr = '0;
  logic [31:0] pre_data = '0;

  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (ram_cs) begin
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      if (ram_we == 4'b0) rdq <= mem[ram_addr];
    end
  end
  assign ram_rdata = rdq;

  typedef struct {
    logic        host;
    logic [31:0] data;
  } exp_t;

  exp_t        q[$];
  logic [31:0] shadow [4096];
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_req(input logic host, input logic [AW-1:0] addr, input logic we,
                          input logic [3:0] wstrb, input logic [31:0] wdata);
    exp_t        e;
    logic [11:0] w;
    w      = addr[AW-1:2];
    e.host = host;
    if (we) begin
      for (int b = 0; b < 4; b++)
        if (wstrb[b]) shadow[w][8*b +: 8] = wdata[8*b +: 8];
      e.data = '0;
    end else begin
      e.data = shadow[w];
    end
    q.push_back(e);
  endtask

  // Runs at every falling edge: retires the expected response, then records new accepts.
  task automatic sb();
    exp_t e;
    if (cpurst) begin
      q.delete();
      chk("rst_core_rsp_valid", core_rsp_valid, 0);
      chk("rst_host_rsp_valid", host_rsp_valid, 0);
    end else if (q.size() > 0) begin
      e = q.pop_front();
      chk("core_rsp_valid", core_rsp_valid, !e.host);
      chk("host_rsp_valid", host_rsp_valid, e.host);
      chk("core_rsp_rdata", core_rsp_rdata, e.host ? 32'h0 : e.data);
      chk("host_rsp_rdata", host_rsp_rdata, e.host ? e.data : 32'h0);
    end else begin
      chk("idle_core_rsp_valid", core_rsp_valid, 0);
      chk("idle_host_rsp_valid", host_rsp_valid, 0);
    end
    chk("single_grant", core_req_ready & host_req_ready, 0);
    if (!cpurst && core_req_valid && core_req_ready)
      push_req(1'b0, core_req_addr, core_req_we, core_req_wstrb, core_req_wdata);
    if (!cpurst && host_req_valid && host_req_ready)
      push_req(1'b1, host_req_addr, host_req_we, host_req_wstrb, host_req_wdata);
  endtask

  task automatic at_neg();
    @(negedge clk);
    sb();
  endtask

  task automatic at_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic core_drv(input logic v, input logic [AW-1:0] a, input logic we,
                          input logic [3:0] s, input logic [31:0] d);
    core_req_valid = v; core_req_addr = a; core_req_we = we;
    core_req_wstrb = s; core_req_wdata = d;
  endtask

  task automatic host_drv(input logic v, input logic [AW-1:0] a, input logic we,
                          input logic [3:0] s, input logic [31:0] d);
    host_req_valid = v; host_req_addr = a; host_req_we = we;
    host_req_wstrb = s; host_req_wdata = d;
  endtask

  logic [11:0] pre_w [6];
  logic [31:0] pre_d [6];
  logic [31:0] b2b   [3];

  initial begin
    pre_w = '{12'h000, 12'h001, 12'h002, 12'h003, 12'h010, 12'h011};
    pre_d = '{32'ha0a0_0001, 32'hb1b1_0002, 32'hc2c2_0003, 32'hd3d3_0004,
              32'h89ab_cdef, 32'h0123_4567};
    b2b   = '{32'ha0a0_0001, 32'hb1b1_0002, 32'hc2c2_0003};
    cpurst = 1'b1;
    core_drv(0, '0, 0, '0, '0);
    host_drv(0, '0, 0, '0, '0);

    for (int i = 0; i < 6; i++) begin
      pre_en = 1'b1; pre_addr = pre_w[i]; pre_data = pre_d[i];
      shadow[pre_w[i]] = pre_d[i];
      at_pos();
    end
    pre_en = 1'b0;

    // Reset state with both requesters asking: ready must stay low.
    core_drv(1, 14'h040, 0, '0, '0);
    host_drv(1, 14'h044, 0, '0, '0);
    at_neg();
    chk("rst_core_ready", core_req_ready, 0);
    chk("rst_host_ready", host_req_ready, 0);
    chk("rst_ram_cs", ram_cs, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_core_rdata", core_rsp_rdata, 0);
    chk("rst_host_rdata", host_rsp_rdata, 0);
    chk("rst_starve_cnt", dut.starve_cnt, 0);
    at_pos();

    // Core-only read of word 0x10.
    cpurst = 1'b0;
    host_drv(0, '0, 0, '0, '0);
    at_neg();
    chk("t1_core_ready", core_req_ready, 1);
    chk("t1_host_ready", host_req_ready, 0);
    chk("t1_ram_cs", ram_cs, 1);
    chk("t1_ram_we", ram_we, 0);
    chk("t1_ram_addr", ram_addr, 12'h010);
    at_pos();
    core_drv(0, '0, 0, '0, '0);
    at_neg();
    chk("t1_rsp_data", core_rsp_rdata, 32'h89ab_cdef);
    at_pos();

    // Host byte-lane write into word 0x11, then core reads the merged word.
    host_drv(1, 14'h044, 1, 4'b0010, 32'h0000_5500);
    at_neg();
    chk("t2_host_ready", host_req_ready, 1);
    chk("t2_core_ready", core_req_ready, 0);
    chk("t2_ram_we", ram_we, 4'b0010);
    chk("t2_ram_addr", ram_addr, 12'h011);
    chk("t2_ram_wdata", ram_wdata, 32'h0000_5500);
    at_pos();
    host_drv(0, '0, 0, '0, '0);
    core_drv(1, 14'h044, 0, '0, '0);
    at_neg();
    chk("t2_host_ack", host_rsp_valid, 1);
    chk("t2_core_ready_rd", core_req_ready, 1);
    at_pos();
    core_drv(0, '0, 0, '0, '0);
    at_neg();
    chk("t2_merged", core_rsp_rdata, 32'h0123_5567);
    at_pos();

    // Write with no byte enables: accepted, no SRAM write, acked.
    core_drv(1, 14'h014, 1, 4'b0000, 32'hffff_ffff);
    at_neg();
    chk("t3_ram_cs", ram_cs, 1);
    chk("t3_ram_we", ram_we, 0);
    at_pos();
    core_drv(0, '0, 0, '0, '0);
    at_neg();
    chk("t3_ack", core_rsp_valid, 1);
    at_pos();

    // Simultaneous requests from a fresh host, held until the host starves.
    core_drv(1, 14'h000, 0, '0, '0);
    host_drv(1, 14'h004, 0, '0, '0);
    for (int c = 0; c < 6; c++) begin
      at_neg();
      chk($sformatf("t4_starve_c%0d", c), dut.starve_cnt, (c <= 4) ? c : 0);
      chk($sformatf("t4_core_ready_c%0d", c), core_req_ready, c != 4);
      chk($sformatf("t4_host_ready_c%0d", c), host_req_ready, c == 4);
      chk($sformatf("t4_ram_addr_c%0d", c), ram_addr, (c == 4) ? 12'h001 : 12'h000);
      at_pos();
    end
    core_drv(0, '0, 0, '0, '0);
    host_drv(0, '0, 0, '0, '0);
    at_neg();
    at_pos();

    // Reset arrives in the response cycle of an accepted read.
    core_drv(1, 14'h00c, 0, '0, '0);
    at_neg();
    chk("t5_core_ready", core_req_ready, 1);
    at_pos();
    cpurst = 1'b1;
    core_drv(0, '0, 0, '0, '0);
    at_neg();
    chk("t5_rst_ram_cs", ram_cs, 0);
    chk("t5_rst_ram_we", ram_we, 0);
    chk("t5_rst_core_rdata", core_rsp_rdata, 0);
    chk("t5_rst_host_rdata", host_rsp_rdata, 0);
    at_pos();
    cpurst = 1'b0;
    at_neg();
    chk("t5_no_late_rsp", core_rsp_valid, 0);
    chk("t5_rsp_pend", dut.u_rsp.rsp_pend, 0);
    at_pos();

    // Host-only back-to-back reads of words 0..2.
    for (int i = 0; i < 3; i++) begin
      host_drv(1, 14'(4 * i), 0, '0, '0);
      at_neg();
      chk($sformatf("t6_host_ready_%0d", i), host_req_ready, 1);
      if (i > 0) chk($sformatf("t6_rdata_%0d", i - 1), host_rsp_rdata, b2b[i - 1]);
      at_pos();
    end
    host_drv(0, '0, 0, '0, '0);
    at_neg();
    chk("t6_rdata_2", host_rsp_rdata, b2b[2]);
    at_pos();
    at_neg();
    chk("end_queue_empty", q.size(), 0);
    at_pos();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dtcm_arbiter.md
# dtcm_arbiter

Shares the single-port, byte-lane data TCM (four 8-bit banks forming one 32-bit word, 16 KB) between two requesters: the core load/store unit and a host port used for program loading and result readback (e.g. reading the tohost/x3 signature area). The arbiter sits between `core_u` and `dsram_u` inside `top`. It grants at most one access per cycle, routes the 1-cycle SRAM read data back to the owner, and guarantees that the host is never starved.

## Interface
- `AW`, 14: byte address width. 16 KB DTCM; word address is `AW-2` bits.
- `STARVE_MAX`, 4: number of consecutive denied host cycles after which the host wins arbitration; legal range 1..15.

- `clk`  in  1: single clock; all state updates on the rising edge.
- `cpurst`  in  1: reset, synchronous, active-high.
- `core_req_valid`  in  1: core request present.
- `core_req_ready`  out  1: core request accepted this cycle.
- `core_req_addr`  in  AW: byte address; bits [1:0] ignored.
- `core_req_we`  in  1: 1 = write, 0 = read.
- `core_req_wstrb`  in  4: byte enables for a write; ignored for a read.
- `core_req_wdata`  in  32: write data.
- `core_rsp_valid`  out  1: one-cycle response pulse.
- `core_rsp_rdata`  out  32: read data; 0 for a write ack.
- `host_req_valid`, `host_req_ready`, `host_req_addr`, `host_req_we`, `host_req_wstrb`, `host_req_wdata`, `host_rsp_valid`, `host_rsp_rdata`: same directions, widths and meaning for the host port.
- `ram_cs`  out  1: SRAM access strobe.
- `ram_we`  out  4: per-byte write enables (bank0..bank3); 0 for a read.
- `ram_addr`  out  AW-2: word address, equal to req_addr[AW-1:2].
- `ram_wdata`  out  32: write data.
- `ram_rdata`  in  32: read data, valid the cycle after `ram_cs` with `ram_we == 0`.

## Operation
- Grant is combinational from the current-cycle valids and the starvation state.
- The core wins by default. The host wins when the core is not valid, or when `starve_cnt == STARVE_MAX`.
- `ready` is asserted only to the granted requester. A request is accepted when `valid && ready`. No backpressure exists on responses.
- On acceptance: `ram_cs = 1`, `ram_we = we ? wstrb : 4'b0`, and address/data are muxed from the winner. When no request is accepted: `ram_cs = 0`, `ram_we = 0`.
- A write with `wstrb == 0` is still accepted and acked, with `ram_we = 0`.
- Response stage registers: `rsp_pend`, `rsp_owner` (CORE/HOST), `rsp_is_rd`.
  - In the next cycle, exactly the owner's `rsp_valid` = 1.
  - `rdata` = `ram_rdata` for a read, 0 for a write.
  - The non-owner's `rdata` = 0.
- Starvation counter `starve_cnt` (4 bits):
  - Increments, saturating at `STARVE_MAX`, each cycle that `host_req_valid && !host_req_ready`.
  - Clears to 0 on host acceptance or when `host_req_valid == 0`.
- When the host wins due to starvation, `core_req_ready = 0` for that cycle. The core holds its request, and the valid/address must stay stable until accepted.
- Back-to-back accepts are permitted every cycle. The response pipeline carries one entry per cycle.

## Timing
- Reset values: all `ready`/`rsp_valid` = 0, `rsp_rdata` = 0, `ram_cs` = 0, `ram_we` = 0, `starve_cnt` = 0, `rsp_pend` = 0.
- While `cpurst` = 1, both `ready` outputs are forced to 0.
- Latency: request accepted in cycle N produces the response in cycle N+1, for reads and writes alike.
- Write data lands in the SRAM at the edge ending cycle N. A read of the same word accepted in N+1 returns the new data.
- Simultaneous valids with `starve_cnt < STARVE_MAX`: core granted.
- With `starve_cnt == STARVE_MAX`: host granted and the counter clears the next cycle.
- Reset asserted while `rsp_pend` = 1: the pending response is dropped and no `rsp_valid` is emitted the following cycle.
- Address wrap: none. `ram_addr` is the truncated `[AW-1:2]` field, and higher address bits are the requester's responsibility.

## Structure
- Package `dtcm_arb_pkg`: owner enum `OWNER_CORE`/`OWNER_HOST`, the default `STARVE_MAX`, and the word-width constant 32.
- One sub-module, `dtcm_arb_rsp_stage`: registers `rsp_pend`/`rsp_owner`/`rsp_is_rd` and demuxes `ram_rdata` to the two response ports.
- Grant logic and the starvation counter stay in the top-level `dtcm_arbiter`.

## Test plan
- **Core-only read:** preload word 0x10 = 0x89abcdef, core reads byte addr 0x40 → `ram_cs` in N, `core_rsp_valid` in N+1 with 0x89abcdef; `host_rsp_valid` stays 0.
- **Host byte write then core read:** host writes addr 0x44, wstrb 0b0010, wdata 0x0000_5500 onto 0x01234567 → core read returns 0x01235567; host gets an ack with rdata 0.
- **Starvation:** core valid every cycle and host valid from cycle 0, `STARVE_MAX` = 4 → host accepted in cycle 4, core `ready` low only in cycle 4, core accepted again in cycle 5.
- **Simultaneous requests, fresh host:** both valid in one cycle with `starve_cnt` = 0 → core granted, `starve_cnt` = 1 in the next cycle.
- **Reset mid-operation:** core read accepted in N, `cpurst` = 1 in N+1 → no `rsp_valid` in N+1 or N+2, and all outputs are at reset values.
- **Back-to-back alternation:** host-only valids for 3 cycles (reads of words 0, 1, 2) → 3 consecutive `host_rsp_valid` pulses with the correct data in order.
